// File: rtl/sram_responder.sv
// Word-addressed SRAM target for the req/addr_ok/data_ok bus.
// Fixed-latency, in-order responses with a cap on outstanding requests.
module sram_responder #(
  parameter int XLEN            = 32,
  parameter int DEPTH_WORDS     = 4096,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              write,
  input  logic [XLEN/8-1:0] wstrb,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              addr_stall,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [XLEN-1:0]   rdata
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int NB    = XLEN / 8;

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [CW-1:0]    cnt;
  logic             acc;
  logic             dok_q;
  logic             last_v;
  logic             last_r;
  logic [XLEN-1:0]  last_d;
  logic             unused_addr_bits;

  assign idx = addr[IDX_W+1:2];
  assign unused_addr_bits = ^{addr[XLEN-1:IDX_W+2], addr[1:0]};

  assign addr_ok = !rst && !addr_stall
                && (cnt < CW'(MAX_OUTSTANDING));
  assign acc     = req && addr_ok;
  assign data_ok = dok_q && !rst;

  // Byte-strobed write into storage on a write accept
  always_ff @(posedge clk) begin
    if (acc && write) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_l1
      assign last_v = acc;
      assign last_r = !write;
      assign last_d = mem[idx];
    end else begin : g_ln
      logic [LATENCY-2:0] sv;
      logic [LATENCY-2:0] sr;
      logic [XLEN-1:0]    sd [LATENCY-1];

      // Valid/kind shift register; cleared to drop in-flight work
      always_ff @(posedge clk) begin
        if (rst) begin
          sv <= '0;
          sr <= '0;
        end else begin
          sv[0] <= acc;
          sr[0] <= !write;
          for (int i = 1; i < LATENCY - 1; i++) begin
            sv[i] <= sv[i-1];
            sr[i] <= sr[i-1];
          end
        end
      end

      // Read word sampled at accept, carried alongside its request
      always_ff @(posedge clk) begin
        sd[0] <= mem[idx];
        for (int i = 1; i < LATENCY - 1; i++) begin
          sd[i] <= sd[i-1];
        end
      end

      assign last_v = sv[LATENCY-2];
      assign last_r = sr[LATENCY-2];
      assign last_d = sd[LATENCY-2];
    end
  endgenerate

  // Final stage: response pulse and held read data
  always_ff @(posedge clk) begin
    if (rst) begin
      dok_q <= 1'b0;
      rdata <= '0;
    end else begin
      dok_q <= last_v;
      if (last_v && last_r) begin
        rdata <= last_d;
      end
    end
  end

  // Outstanding-request counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case ({acc, data_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_underflow : assert property (
    @(posedge clk) disable iff (rst) data_ok |-> (cnt != '0)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: vector table plus scoreboarded
// corner sequences (limit, stall, mid-flight reset).
module tb_sram_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic        write;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_stall;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  sram_responder #(
    .XLEN(32),
    .DEPTH_WORDS(4096),
    .LATENCY(LAT),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .write(write),
    .wstrb(wstrb),
    .addr(addr),
    .wdata(wdata),
    .addr_stall(addr_stall),
    .addr_ok(addr_ok),
    .data_ok(data_ok),
    .rdata(rdata)
  );

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp;
  int          n_bad;
  int          cyc;
  logic [31:0] exp_rdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // Response monitor: pops the scoreboard on every data_ok
  always @(negedge clk) begin
    exp_t e;
    if (data_ok) begin
      if (sb.size() == 0) begin
        chk("spurious_data_ok", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("latency", 32'(cyc - e.cyc), 32'(LAT));
        if (e.rd) exp_rdata = e.data;
        chk("rdata", rdata, exp_rdata);
      end
    end else if (sb.size() > 0 && cyc >= sb[0].cyc + LAT) begin
      chk("missing_data_ok", 32'd0, 32'd1);
      e = sb.pop_front();
    end
  end

  task automatic issue(input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] ex, output int acc_cyc);
    int k;
    k     = 0;
    req   = 1'b1;
    write = wr;
    addr  = a;
    wdata = wd;
    wstrb = ws;
    do begin
      @(negedge clk);
      k++;
    end while (!addr_ok && k < 50);
    if (!addr_ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req     = 1'b0;
      acc_cyc = -1;
      return;
    end
    sb.push_back('{rd: !wr, data: ex, cyc: cyc});
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t vt[16];
    int   a0, a1, a2, a3;
    int   k;

    vt[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0};
    vt[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0};
    vt[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0};
    vt[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD};
    vt[5]  = '{1'b0, 32'h22,   32'h0,        4'hF, 32'h11BB33DD};
    vt[6]  = '{1'b1, 32'h24,   32'h55667788, 4'hF, 32'h0};
    vt[7]  = '{1'b1, 32'h24,   32'hFFFFFFFF, 4'h0, 32'h0};
    vt[8]  = '{1'b0, 32'h24,   32'h0,        4'h0, 32'h55667788};
    vt[9]  = '{1'b1, 32'h28,   32'h00000000, 4'hF, 32'h0};
    vt[10] = '{1'b1, 32'h28,   32'hA5A5A5A5, 4'hA, 32'h0};
    vt[11] = '{1'b0, 32'h28,   32'h0,        4'h0, 32'hA500A500};
    vt[12] = '{1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, 32'h0};
    vt[13] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D};
    vt[14] = '{1'b1, 32'h30,   32'h01020304, 4'h8, 32'h0};
    vt[15] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF};

    n_cmp      = 0;
    n_bad      = 0;
    cyc        = 0;
    exp_rdata  = 32'h0;
    rst        = 1'b1;
    req        = 1'b0;
    write      = 1'b0;
    wstrb      = 4'h0;
    addr       = 32'h0;
    wdata      = 32'h0;
    addr_stall = 1'b0;

    repeat (2) begin
      @(negedge clk);
      chk("reset_addr_ok", 32'(addr_ok), 32'd0);
      chk("reset_data_ok", 32'(data_ok), 32'd0);
      chk("reset_rdata", rdata, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_addr_ok", 32'(addr_ok), 32'd1);
    chk("post_reset_rdata", rdata, 32'h0);
    idle(1);

    for (int i = 0; i < 16; i++) begin
      issue(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wstrb,
            vt[i].exp, a0);
    end
    idle(4);

    issue(1'b1, 32'h0, 32'h0A0A0A0A, 4'hF, 32'h0, a0);
    issue(1'b1, 32'h4, 32'h0B0B0B0B, 4'hF, 32'h0, a0);
    issue(1'b1, 32'h8, 32'h0C0C0C0C, 4'hF, 32'h0, a0);
    idle(4);

    issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h0A0A0A0A, a0);
    issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h0B0B0B0B, a1);
    issue(1'b0, 32'h8, 32'h0, 4'h0, 32'h0C0C0C0C, a2);
    chk("limit_gap01", 32'(a1 - a0), 32'd1);
    chk("limit_gap12", 32'(a2 - a1), 32'd2);
    idle(4);

    issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h0B0B0B0B, a0);
    addr_stall = 1'b1;
    req        = 1'b1;
    write      = 1'b0;
    addr       = 32'h8;
    k          = 0;
    repeat (4) begin
      @(negedge clk);
      if (addr_ok) k++;
      addr = addr + 32'h4;
    end
    chk("stall_accepts", 32'(k), 32'd0);
    @(posedge clk);
    #1;
    addr_stall = 1'b0;
    issue(1'b0, 32'h8, 32'h0, 4'h0, 32'h0C0C0C0C, a1);
    chk("stall_release", 32'(a1 - a0), 32'd5);
    idle(4);

    issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h0A0A0A0A, a0);
    issue(1'b0, 32'h4, 32'h0, 4'h0, 32'h0B0B0B0B, a1);
    rst = 1'b1;
    sb.delete();
    exp_rdata = 32'h0;
    @(negedge clk);
    chk("midrst_addr_ok", 32'(addr_ok), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    @(negedge clk);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_addr_ok_after", 32'(addr_ok), 32'd1);
    @(posedge clk);
    #1;
    issue(1'b0, 32'h8, 32'h0, 4'h0, 32'h0C0C0C0C, a2);
    issue(1'b0, 32'h0, 32'h0, 4'h0, 32'h0A0A0A0A, a3);
    chk("midrst_count_clear", 32'(a3 - a2), 32'd1);

    k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
